// File: rtl/nand_gate_tester_pkg.sv
// Shared types for the NAND gate tester: FSM state encoding.
// Imported by the tester top and the vector generator.
package nand_gate_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nand_vec_gen.sv
// Vector counter with terminal-count flag and per-channel stimulus build (ROTATE_EN rotates per channel).
// Latency: stim/last are combinational from the registered counter; clr/inc take effect next edge.
// Backpressure: none; the counter advances only when the sequencer asserts inc.
module nand_vec_gen
    import nand_gate_tester_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         inc,
    output logic [INPUTS-1:0]            vec,
    output logic                         last,
    output logic [CHANNELS*INPUTS-1:0]   stim
);

    localparam int unsigned TERM_I = (1 << INPUTS) - 1;
    localparam logic [INPUTS:0] TERM = TERM_I[INPUTS:0];

    // One spare bit so the terminal count never aliases with a wrapped zero.
    logic [INPUTS:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign vec  = cnt[INPUTS-1:0];
    assign last = (cnt == TERM);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam int ROT = k % INPUTS;
        for (genvar i = 0; i < INPUTS; i++) begin : g_bit
`ifdef ROTATE_EN
            assign stim[k*INPUTS + ((i + ROT) % INPUTS)] = vec[i];
`else
            assign stim[k*INPUTS + i] = vec[i];
`endif
        end
    end

endmodule

// File: rtl/nand_gate_tester.sv
// Exhaustive NAND bank tester: sequences all input vectors, compares outputs, reports per-channel results.
// Latency: 2^INPUTS*(SETTLE+1) cycles from start to the done pulse; optional ROTATE_EN macro rotates stimulus per channel.
// Backpressure: none; start is only honoured when idle (or on the done cycle), otherwise ignored.
module nand_gate_tester
    import nand_gate_tester_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4,
    parameter int SETTLE   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CHANNELS-1:0]          resp,
    output logic [CHANNELS*INPUTS-1:0]   stim,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CHANNELS-1:0]          fail_chan,
    output logic [INPUTS-1:0]            fail_vec
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t                       state;
    logic [SW-1:0]                settle_cnt;
    logic [INPUTS-1:0]            vec;
    logic                         vec_last;
    logic [CHANNELS*INPUTS-1:0]   gen_stim;
    logic [CHANNELS-1:0]          expected;
    logic [CHANNELS-1:0]          mism;
    logic                         begin_run;
    logic                         vec_inc;

    // A held start re-launches straight out of DONE so back-to-back runs have no idle gap.
    assign begin_run = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign vec_inc   = (state == ST_CHECK) && !vec_last;

    nand_vec_gen #(
        .CHANNELS (CHANNELS),
        .INPUTS   (INPUTS)
    ) u_vec_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (begin_run),
        .inc   (vec_inc),
        .vec   (vec),
        .last  (vec_last),
        .stim  (gen_stim)
    );

    for (genvar k = 0; k < CHANNELS; k++) begin : g_exp
        assign expected[k] = ~&gen_stim[k*INPUTS +: INPUTS];
    end

    assign mism = resp ^ expected;
    assign stim = busy ? gen_stim : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_chan  <= '0;
            fail_vec   <= '0;
        end else if (begin_run) begin
            state      <= ST_APPLY;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_chan  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                end
                ST_APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    fail_chan <= fail_chan | mism;
                    if ((fail_chan == '0) && (mism != '0)) begin
                        fail_vec <= vec;
                    end
                    if (vec_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= ~|(fail_chan | mism);
                    end else begin
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
